down_count_monitor: RTL and testbench
=====================================

# down_count_monitor

Checker stage that sits directly downstream of the 3-bit down counter and consumes its `count` output. It tracks the count stream, locks onto a valid decrement sequence (step of −1 modulo 2^WIDTH, 0 → max is legal), and flags any deviation. It also reports wrap-arounds and keeps saturating wrap and error tallies. Its flags and tallies feed the status/debug logic and the counter's self-check benches.

## Interface
- `WIDTH`, default 3: width of the monitored count.
- `SYNC_LEN`, default 2: consecutive valid decrements needed to enter LOCKED; legal range 1..15.
- `WRAP_W`, default 8: width of the wrap tally.
- `ERR_W`, default 4: width of the error tally.

- `clk` input 1: single clock; all logic updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `en` input 1: `count` is sampled on this edge when high.
- `count` input WIDTH: value from the upstream down counter.
- `locked` output 1: high while the FSM is in LOCKED.
- `err` output 1: one-cycle pulse on a mismatch while LOCKED.
- `wrap` output 1: one-cycle pulse on a valid 0 → 2^WIDTH−1 step.
- `wrap_cnt` output WRAP_W: number of wraps seen; saturates at all-ones.
- `err_cnt` output ERR_W: number of errors seen; saturates at all-ones.
- `expected` output WIDTH: next value the monitor expects; 0 while UNLOCKED.

## Operation
- Internal state:
  - `prev` (WIDTH): last sampled count.
  - `run` (4 bits): valid-step counter.
  - `state`: UNLOCKED, ACQUIRE or LOCKED.
- Valid step: `count == prev − 1` modulo 2^WIDTH, computed at WIDTH bits with natural wrap. A repeated value (`count == prev`) is not a valid step.
- The FSM only evaluates on edges where `en` = 1. When `en` = 0:
  - all state, tallies and `expected` hold;
  - `err` and `wrap` are 0.
- UNLOCKED:
  - set `prev` = `count`, `run` = 0;
  - go to ACQUIRE.
- ACQUIRE:
  - valid step: `run` += 1; if the new `run` equals SYNC_LEN, go to LOCKED;
  - invalid step: `run` = 0, stay in ACQUIRE, no `err`;
  - `prev` = `count` in both cases.
- LOCKED:
  - valid step: stay in LOCKED;
  - invalid step: pulse `err`, `err_cnt` += 1 (saturating), `run` = 0, go to ACQUIRE;
  - `prev` = `count` in both cases.
- `wrap` fires on any valid step with `prev` = 0 and `count` = 2^WIDTH−1, in ACQUIRE or LOCKED. `wrap_cnt` += 1, saturating.
- `expected` = `prev − 1` (mod 2^WIDTH) in ACQUIRE and LOCKED, 0 in UNLOCKED. It is a registered output, updated with `prev`.
- `rst` has priority over `en`. A reset mid-sequence discards lock, `run` and both tallies.

## Timing
- Reset values, visible the cycle after an edge with `rst` = 1: `locked` = 0, `err` = 0, `wrap` = 0, `wrap_cnt` = 0, `err_cnt` = 0, `expected` = 0, `prev` = 0, `run` = 0, state UNLOCKED.
- All outputs are registered. Latency is 1 cycle from the sampling edge to the output change.
- `err` and `wrap` are high for exactly the one cycle following the edge that caused them. They cannot be high in consecutive cycles unless `en` is held high and consecutive events occur.
- Lock latency from UNLOCKED is 1 + SYNC_LEN sampled edges of valid data.
- After an error, the monitor relocks after SYNC_LEN further valid steps. The offending sample counts as the new `prev`.
- Tally saturation: at all-ones, further increments hold the value. The pulse outputs still fire.

## Test plan
1. Reset: hold `rst` = 1 for 2 cycles with `en` = 1 and `count` toggling. Required: all outputs 0 and state UNLOCKED after the first reset edge.
2. Lock plus wrap (defaults): `en` = 1, `count` = 0, 7, 6 on successive edges.
   - After the 7 edge: `wrap` = 1 for one cycle, `wrap_cnt` = 1.
   - After the 6 edge: `locked` = 1, `expected` = 5.
3. Full lap: continue with 5, 4, 3, 2, 1, 0, 7. Required: `err` stays 0, a single `wrap` pulse after the 7 edge, `wrap_cnt` = 2, `locked` stays 1.
4. Error and relock: while locked with `expected` = 3, drive 5.
   - Next cycle: `err` = 1, `err_cnt` = 1, `locked` = 0, `expected` = 4.
   - Then drive 4, 3: `locked` = 1 after the 3 edge.
5. Gating and hold:
   - `en` = 0 for 3 cycles with arbitrary `count`: no output changes, no pulses.
   - Then `en` = 1 with `count` equal to `prev` while LOCKED: `err` pulse, `locked` = 0.
6. Saturation and mid-run reset:
   - Inject 20 mismatches, relocking between them. Required: `err_cnt` = 15 (ERR_W = 4) and a pulse on every one.
   - Then assert `rst` while locked: `locked` = 0 and `err_cnt` = 0 on the next cycle.

Source files
------------

// File: rtl/down_count_monitor.sv
// down_count_monitor
// Watches the output of a down counter, locks onto a clean decrement
// sequence (modulo 2^WIDTH, so 0 -> max is legal) and flags deviations.
// Also reports wrap-arounds and keeps saturating wrap and error tallies.
// Every output comes straight from a register or from the state register.
module down_count_monitor #(
  parameter int WIDTH    = 3,
  parameter int SYNC_LEN = 2,
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [WIDTH-1:0]  count,
  output logic              locked,
  output logic              err,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WIDTH-1:0]  expected
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    ACQUIRE  = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  localparam logic [3:0] SYNC_LEN_L = 4'(SYNC_LEN);

  state_t              state, state_nx;
  logic [WIDTH-1:0]    prev, prev_nx;
  logic [WIDTH-1:0]    expected_nx;
  logic [3:0]          run, run_nx;
  logic                err_nx, wrap_nx;
  logic [WRAP_W-1:0]   wrap_cnt_nx;
  logic [ERR_W-1:0]    err_cnt_nx;

  logic [WIDTH-1:0]    prev_m1;
  logic [WIDTH-1:0]    count_m1;
  logic [3:0]          run_inc;
  logic                step_ok;

  // A step is valid only when count is exactly one below the previous sample;
  // WIDTH-bit arithmetic gives the 0 -> max wrap for free, and a repeat fails.
  assign prev_m1  = prev - WIDTH'(1);
  assign count_m1 = count - WIDTH'(1);
  assign run_inc  = run + 4'd1;
  assign step_ok  = (count == prev_m1);

  assign locked   = (state == LOCKED);

  // Next-state and next-output logic; everything holds unless en samples a value.
  always_comb begin
    state_nx    = state;
    prev_nx     = prev;
    run_nx      = run;
    expected_nx = expected;
    err_nx      = 1'b0;
    wrap_nx     = 1'b0;
    wrap_cnt_nx = wrap_cnt;
    err_cnt_nx  = err_cnt;

    if (en) begin
      case (state)
        UNLOCKED: begin
          prev_nx     = count;
          run_nx      = 4'd0;
          expected_nx = count_m1;
          state_nx    = ACQUIRE;
        end
        ACQUIRE: begin
          prev_nx     = count;
          expected_nx = count_m1;
          if (step_ok) begin
            run_nx = run_inc;
            if (run_inc == SYNC_LEN_L) begin
              state_nx = LOCKED;
            end
          end else begin
            run_nx = 4'd0;
          end
        end
        LOCKED: begin
          prev_nx     = count;
          expected_nx = count_m1;
          if (!step_ok) begin
            err_nx   = 1'b1;
            run_nx   = 4'd0;
            state_nx = ACQUIRE;
            if (err_cnt != '1) begin
              err_cnt_nx = err_cnt + ERR_W'(1);
            end
          end
        end
        default: begin
          state_nx    = UNLOCKED;
          run_nx      = 4'd0;
          expected_nx = '0;
        end
      endcase

      // A wrap is a valid step out of zero, seen whenever a previous sample exists.
      if ((state == ACQUIRE || state == LOCKED) && step_ok && (prev == '0)) begin
        wrap_nx = 1'b1;
        if (wrap_cnt != '1) begin
          wrap_cnt_nx = wrap_cnt + WRAP_W'(1);
        end
      end
    end
  end

  // State and output registers with synchronous reset taking priority over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= UNLOCKED;
      prev     <= '0;
      run      <= 4'd0;
      expected <= '0;
      err      <= 1'b0;
      wrap     <= 1'b0;
      wrap_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      state    <= state_nx;
      prev     <= prev_nx;
      run      <= run_nx;
      expected <= expected_nx;
      err      <= err_nx;
      wrap     <= wrap_nx;
      wrap_cnt <= wrap_cnt_nx;
      err_cnt  <= err_cnt_nx;
    end
  end

endmodule

// File: tb/tb_down_count_monitor.sv
// tb_down_count_monitor
// Directed scenarios followed by a randomized run, all checked against a
// behavioural model of the monitor built from plain integer arithmetic.
module tb_down_count_monitor;

  localparam int WIDTH    = 3;
  localparam int SYNC_LEN = 2;
  localparam int MODV     = 1 << WIDTH;
  localparam int WRAP_MAX = 255;
  localparam int ERR_MAX  = 15;

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             locked;
  logic             err;
  logic             wrap;
  logic [7:0]       wrap_cnt;
  logic [3:0]       err_cnt;
  logic [WIDTH-1:0] expected;

  int n_checks;
  int n_pass;

  // Behavioural model state
  bit m_have_prev;
  bit m_locked;
  int m_streak;
  int m_prev;
  int m_expected;
  bit m_err;
  bit m_wrap;
  int m_wraps;
  int m_errs;

  down_count_monitor #(
    .WIDTH(WIDTH), .SYNC_LEN(SYNC_LEN), .WRAP_W(8), .ERR_W(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .count(count),
    .locked(locked), .err(err), .wrap(wrap),
    .wrap_cnt(wrap_cnt), .err_cnt(err_cnt), .expected(expected)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference behaviour for one rising edge
  task automatic model_edge(input bit r, input bit e, input int c);
    bit good;
    if (r) begin
      m_have_prev = 0; m_locked = 0; m_streak = 0; m_prev = 0;
      m_expected = 0; m_err = 0; m_wrap = 0; m_wraps = 0; m_errs = 0;
    end else if (!e) begin
      m_err = 0; m_wrap = 0;
    end else begin
      m_err = 0; m_wrap = 0;
      if (!m_have_prev) begin
        m_have_prev = 1;
        m_streak = 0;
      end else begin
        good = (c == (m_prev + MODV - 1) % MODV);
        if (good) begin
          if (m_prev == 0) begin
            m_wrap = 1;
            if (m_wraps < WRAP_MAX) m_wraps++;
          end
          if (!m_locked) begin
            m_streak++;
            if (m_streak == SYNC_LEN) m_locked = 1;
          end
        end else begin
          if (m_locked) begin
            m_err = 1;
            if (m_errs < ERR_MAX) m_errs++;
            m_locked = 0;
          end
          m_streak = 0;
        end
      end
      m_prev = c;
      m_expected = (c + MODV - 1) % MODV;
    end
  endtask

  // Drive one sample away from the active edge, then let the edge happen
  task automatic applyStimulus(input bit r, input bit e, input int c);
    @(negedge clk);
    rst   = r;
    en    = e;
    count = WIDTH'(c);
    @(posedge clk);
    model_edge(r, e, c);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 1, i * 5 + 2);
      n_checks++;
      if ({locked, err, wrap} !== 3'b000) $display("[TB] FAIL reset_flags: got %b, want 000", {locked, err, wrap});
      else n_pass++;
      n_checks++;
      if (wrap_cnt !== 8'd0 || err_cnt !== 4'd0 || expected !== 3'd0)
        $display("[TB] FAIL reset_counts: got wrap_cnt=%0d err_cnt=%0d expected=%0d, want 0 0 0", wrap_cnt, err_cnt, expected);
      else n_pass++;
    end
  endtask

  task automatic test_lock_wrap();
    applyStimulus(0, 1, 0);
    n_checks++;
    if (locked !== 1'b0 || expected !== 3'd7) $display("[TB] FAIL first_sample: got locked=%0d expected=%0d, want 0 7", locked, expected);
    else n_pass++;
    applyStimulus(0, 1, 7);
    n_checks++;
    if (wrap !== 1'b1 || wrap_cnt !== 8'd1) $display("[TB] FAIL wrap_pulse: got wrap=%0d wrap_cnt=%0d, want 1 1", wrap, wrap_cnt);
    else n_pass++;
    n_checks++;
    if (locked !== 1'b0) $display("[TB] FAIL early_lock: got %0d, want 0", locked);
    else n_pass++;
    applyStimulus(0, 1, 6);
    n_checks++;
    if (locked !== 1'b1 || expected !== 3'd5 || wrap !== 1'b0)
      $display("[TB] FAIL lock: got locked=%0d expected=%0d wrap=%0d, want 1 5 0", locked, expected, wrap);
    else n_pass++;
  endtask

  task automatic test_full_lap();
    int seq[7] = '{5, 4, 3, 2, 1, 0, 7};
    int pulses = 0;
    int bad = 0;
    foreach (seq[i]) begin
      applyStimulus(0, 1, seq[i]);
      if (wrap === 1'b1) pulses++;
      if (err !== 1'b0 || locked !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) $display("[TB] FAIL lap_steady: got %0d bad cycles, want 0", bad);
    else n_pass++;
    n_checks++;
    if (pulses != 1 || wrap !== 1'b1 || wrap_cnt !== 8'd2)
      $display("[TB] FAIL lap_wrap: got pulses=%0d last_wrap=%0d wrap_cnt=%0d, want 1 1 2", pulses, wrap, wrap_cnt);
    else n_pass++;
  endtask

  task automatic test_error_relock();
    applyStimulus(0, 1, 6);
    applyStimulus(0, 1, 5);
    applyStimulus(0, 1, 4);
    n_checks++;
    if (expected !== 3'd3 || locked !== 1'b1) $display("[TB] FAIL pre_err: got expected=%0d locked=%0d, want 3 1", expected, locked);
    else n_pass++;
    applyStimulus(0, 1, 5);
    n_checks++;
    if (err !== 1'b1 || err_cnt !== 4'd1 || locked !== 1'b0 || expected !== 3'd4)
      $display("[TB] FAIL err_pulse: got err=%0d err_cnt=%0d locked=%0d expected=%0d, want 1 1 0 4", err, err_cnt, locked, expected);
    else n_pass++;
    applyStimulus(0, 1, 4);
    n_checks++;
    if (err !== 1'b0 || locked !== 1'b0) $display("[TB] FAIL relock_mid: got err=%0d locked=%0d, want 0 0", err, locked);
    else n_pass++;
    applyStimulus(0, 1, 3);
    n_checks++;
    if (locked !== 1'b1) $display("[TB] FAIL relock: got %0d, want 1", locked);
    else n_pass++;
  endtask

  task automatic test_gating();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, $urandom_range(0, 7));
      n_checks++;
      if (locked !== 1'b1 || err !== 1'b0 || wrap !== 1'b0 || expected !== 3'd2 || wrap_cnt !== 8'd2 || err_cnt !== 4'd1)
        $display("[TB] FAIL gate_hold: got locked=%0d err=%0d wrap=%0d expected=%0d wrap_cnt=%0d err_cnt=%0d, want 1 0 0 2 2 1",
                 locked, err, wrap, expected, wrap_cnt, err_cnt);
      else n_pass++;
    end
    applyStimulus(0, 1, 3);
    n_checks++;
    if (err !== 1'b1 || locked !== 1'b0 || err_cnt !== 4'd2)
      $display("[TB] FAIL repeat_err: got err=%0d locked=%0d err_cnt=%0d, want 1 0 2", err, locked, err_cnt);
    else n_pass++;
  endtask

  task automatic test_saturation();
    int want_cnt;
    int missed = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(0, 1, (m_prev + MODV - 1) % MODV);
      applyStimulus(0, 1, (m_prev + MODV - 1) % MODV);
      if (locked !== 1'b1) missed++;
      applyStimulus(0, 1, m_prev);
      want_cnt = (3 + k > ERR_MAX) ? ERR_MAX : 3 + k;
      n_checks++;
      if (err !== 1'b1 || err_cnt !== 4'(want_cnt))
        $display("[TB] FAIL sat_err%0d: got err=%0d err_cnt=%0d, want 1 %0d", k, err, err_cnt, want_cnt);
      else n_pass++;
    end
    n_checks++;
    if (missed != 0 || err_cnt !== 4'd15) $display("[TB] FAIL sat_final: got missed_locks=%0d err_cnt=%0d, want 0 15", missed, err_cnt);
    else n_pass++;
    applyStimulus(0, 1, (m_prev + MODV - 1) % MODV);
    applyStimulus(0, 1, (m_prev + MODV - 1) % MODV);
    n_checks++;
    if (locked !== 1'b1) $display("[TB] FAIL sat_relock: got %0d, want 1", locked);
    else n_pass++;
    applyStimulus(1, 1, (m_prev + MODV - 1) % MODV);
    n_checks++;
    if (locked !== 1'b0 || err_cnt !== 4'd0 || wrap_cnt !== 8'd0 || expected !== 3'd0)
      $display("[TB] FAIL mid_reset: got locked=%0d err_cnt=%0d wrap_cnt=%0d expected=%0d, want 0 0 0 0", locked, err_cnt, wrap_cnt, expected);
    else n_pass++;
  endtask

  task automatic test_random();
    int bad = 0;
    int c;
    for (int i = 0; i < 400; i++) begin
      c = ($urandom_range(0, 9) < 7) ? (m_prev + MODV - 1) % MODV : int'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 59) == 0, $urandom_range(0, 4) != 0, c);
      n_checks++;
      if (locked !== m_locked || err !== m_err || wrap !== m_wrap || expected !== 3'(m_expected) ||
          wrap_cnt !== 8'(m_wraps) || err_cnt !== 4'(m_errs)) begin
        if (bad < 10)
          $display("[TB] FAIL random_cycle%0d: got locked=%0d err=%0d wrap=%0d expected=%0d wrap_cnt=%0d err_cnt=%0d, want %0d %0d %0d %0d %0d %0d",
                   i, locked, err, wrap, expected, wrap_cnt, err_cnt, m_locked, m_err, m_wrap, m_expected, m_wraps, m_errs);
        bad++;
      end else n_pass++;
    end
  endtask

  // Scenario sequence
  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1; en = 1'b0; count = '0;
    model_edge(1, 0, 0);
    test_reset();
    test_lock_wrap();
    test_full_lap();
    test_error_relock();
    test_gating();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
